// File: rtl/dio24_btn_events.sv
// Button gesture decoder: classifies short, long and double presses per button
// and delivers them through a single valid/ready event register.
module dio24_btn_events #(
  parameter int NUM_BUTTONS = 2,
  parameter int TICK_BITS   = 16,
  parameter int CNT_BITS    = 12,
  parameter int LONG_TICKS  = 1000,
  parameter int DBL_TICKS   = 250,
  localparam int IDX_W      = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] btn_status,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDX_W-1:0]       evt_btn,
  output logic [1:0]             evt_code,
  output logic                   evt_overrun,
  input  logic                   ovr_clr
);

  typedef enum logic [2:0] {IDLE, PRESS, WAIT2, PRESS2, HOLD} state_t;

  localparam logic [1:0] CODE_SHORT = 2'b01;
  localparam logic [1:0] CODE_LONG  = 2'b10;
  localparam logic [1:0] CODE_DBL   = 2'b11;
  localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_TICKS - 1);
  localparam logic [CNT_BITS-1:0] DBL_LAST  = CNT_BITS'(DBL_TICKS - 1);

  state_t                state     [NUM_BUTTONS];
  state_t                state_nxt [NUM_BUTTONS];
  logic [CNT_BITS-1:0]   cnt       [NUM_BUTTONS];
  logic [1:0]            pcode     [NUM_BUTTONS];
  logic [1:0]            ecode     [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] pend, emit, take;
  logic [TICK_BITS-1:0]  presc;
  logic                  tick, loadable, any_pend, ovr_set;
  logic [IDX_W-1:0]      sel;
  logic [1:0]            sel_code;

  assign tick = &presc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc <= '0;
    else          presc <= presc + 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      state_nxt[i] = state[i];
      emit[i]      = 1'b0;
      ecode[i]     = CODE_SHORT;
      case (state[i])
        IDLE: if (btn_status[i]) state_nxt[i] = PRESS;
        PRESS: begin
          // Long-press qualification takes priority over a release on the same cycle
          if (tick && cnt[i] == LONG_LAST && btn_status[i]) begin
            state_nxt[i] = HOLD;
            emit[i]      = 1'b1;
            ecode[i]     = CODE_LONG;
          end else if (!btn_status[i]) begin
            state_nxt[i] = WAIT2;
          end
        end
        WAIT2: begin
          if (btn_status[i]) begin
            state_nxt[i] = PRESS2;
          end else if (tick && cnt[i] == DBL_LAST) begin
            state_nxt[i] = IDLE;
            emit[i]      = 1'b1;
            ecode[i]     = CODE_SHORT;
          end
        end
        PRESS2: if (!btn_status[i]) begin
          state_nxt[i] = IDLE;
          emit[i]      = 1'b1;
          ecode[i]     = CODE_DBL;
        end
        HOLD: if (!btn_status[i]) state_nxt[i] = IDLE;
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    loadable = !evt_valid || evt_ready;
    any_pend = 1'b0;
    sel      = '0;
    sel_code = '0;
    take     = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (pend[i] && !any_pend) begin
        any_pend = 1'b1;
        sel      = IDX_W'(i);
        sel_code = pcode[i];
        take[i]  = loadable;
      end
    end
    ovr_set = |(emit & pend & ~take);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        pcode[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state[i] <= state_nxt[i];
        if (state_nxt[i] != state[i])      cnt[i] <= '0;
        else if (tick && cnt[i] != '1)     cnt[i] <= cnt[i] + 1'b1;
        // A fresh emit re-arms pending even when the old event is being taken now
        if (emit[i]) begin
          pend[i]  <= 1'b1;
          pcode[i] <= ecode[i];
        end else if (take[i]) begin
          pend[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid   <= 1'b0;
      evt_btn     <= '0;
      evt_code    <= '0;
      evt_overrun <= 1'b0;
    end else begin
      if (ovr_set)      evt_overrun <= 1'b1;
      else if (ovr_clr) evt_overrun <= 1'b0;
      if (loadable) begin
        if (any_pend) begin
          evt_valid <= 1'b1;
          evt_btn   <= sel;
          evt_code  <= sel_code;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dio24_btn_events.sv
// Directed bench for dio24_btn_events with a fast timebase (tick every 4 clocks).
module tb_dio24_btn_events;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] btn_status = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [0:0] evt_btn;
  logic [1:0] evt_code;
  logic       evt_overrun;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ev_btn  [256];
  int ev_code [256];
  int ev_cyc  [256];
  int ev_n = 0;

  dio24_btn_events #(
    .NUM_BUTTONS(2),
    .TICK_BITS(2),
    .CNT_BITS(12),
    .LONG_TICKS(8),
    .DBL_TICKS(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_status(btn_status),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn(evt_btn),
    .evt_code(evt_code),
    .evt_overrun(evt_overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshaken event with the clock edge count that made it visible
  always @(negedge clk) begin
    if (evt_valid && evt_ready && ev_n < 256) begin
      ev_btn[ev_n]  = int'(evt_btn);
      ev_code[ev_n] = int'(evt_code);
      ev_cyc[ev_n]  = cyc;
      ev_n          = ev_n + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int    b;
    int    hold;
    int    exp_btn;
    int    exp_code;
    bit    from_press;
    int    lmin;
    int    lmax;
    string name;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int base, t_press, t_rel, t_ref, lat, rr;

    tbl[0] = '{b: 0, hold: 10, exp_btn: 0, exp_code: 1, from_press: 1'b0, lmin: 13, lmax: 17, name: "short0"};
    tbl[1] = '{b: 1, hold: 60, exp_btn: 1, exp_code: 2, from_press: 1'b1, lmin: 29, lmax: 33, name: "long1"};
    tbl[2] = '{b: 1, hold: 5,  exp_btn: 1, exp_code: 1, from_press: 1'b0, lmin: 13, lmax: 17, name: "short1"};
    tbl[3] = '{b: 0, hold: 40, exp_btn: 0, exp_code: 2, from_press: 1'b1, lmin: 29, lmax: 33, name: "long0"};

    cyc_wait(3);
    @(negedge clk);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_btn", int'(evt_btn), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_ovr", int'(evt_overrun), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc_wait(5);

    for (int k = 0; k < 4; k++) begin
      base = ev_n;
      btn_status[tbl[k].b] = 1'b1;
      t_press = cyc + 1;
      cyc_wait(tbl[k].hold);
      btn_status = '0;
      t_rel = cyc + 1;
      cyc_wait(40);
      chk({tbl[k].name, "_count"}, ev_n - base, 1);
      if (ev_n > base) begin
        t_ref = tbl[k].from_press ? t_press : t_rel;
        lat = ev_cyc[base] - t_ref;
        chk({tbl[k].name, "_btn"}, ev_btn[base], tbl[k].exp_btn);
        chk({tbl[k].name, "_code"}, ev_code[base], tbl[k].exp_code);
        chk_rng({tbl[k].name, "_lat"}, lat, tbl[k].lmin, tbl[k].lmax);
      end
    end

    // Double press
    base = ev_n;
    btn_status[0] = 1'b1; cyc_wait(8);
    btn_status[0] = 1'b0; cyc_wait(6);
    btn_status[0] = 1'b1; cyc_wait(8);
    btn_status[0] = 1'b0;
    t_rel = cyc + 1;
    cyc_wait(30);
    chk("dbl_count", ev_n - base, 1);
    if (ev_n > base) begin
      chk("dbl_btn", ev_btn[base], 0);
      chk("dbl_code", ev_code[base], 3);
      chk("dbl_lat", ev_cyc[base] - t_rel, 1);
    end

    // Arbitration with consumer stalled
    base = ev_n;
    evt_ready = 1'b0;
    btn_status = 2'b11;
    cyc_wait(40);
    btn_status = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arb_hold_valid", int'(evt_valid), 1);
      chk("arb_hold_btn", int'(evt_btn), 0);
      chk("arb_hold_code", int'(evt_code), 2);
      @(posedge clk); #1;
    end
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    @(negedge clk);
    chk("arb_next_valid", int'(evt_valid), 1);
    chk("arb_next_btn", int'(evt_btn), 1);
    chk("arb_next_code", int'(evt_code), 2);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb_drain_valid", int'(evt_valid), 0);
    chk("arb_events", ev_n - base, 2);
    cyc_wait(20);

    // Overrun: output occupied by btn1, two shorts on btn0
    evt_ready = 1'b0;
    btn_status[1] = 1'b1; cyc_wait(5);
    btn_status[1] = 1'b0; cyc_wait(25);
    @(negedge clk);
    chk("ovr_occ_valid", int'(evt_valid), 1);
    chk("ovr_occ_btn", int'(evt_btn), 1);
    btn_status[0] = 1'b1; cyc_wait(5);
    btn_status[0] = 1'b0; cyc_wait(25);
    @(negedge clk);
    chk("ovr_first", int'(evt_overrun), 0);
    btn_status[0] = 1'b1; cyc_wait(5);
    btn_status[0] = 1'b0; cyc_wait(25);
    @(negedge clk);
    chk("ovr_set", int'(evt_overrun), 1);
    cyc_wait(3);
    @(negedge clk);
    chk("ovr_sticky", int'(evt_overrun), 1);
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", int'(evt_overrun), 0);
    base = ev_n;
    @(posedge clk); #1;
    evt_ready = 1'b1;
    cyc_wait(5);
    chk("ovr_drain_count", ev_n - base, 2);
    if (ev_n - base >= 2) begin
      chk("ovr_drain_b1", ev_btn[base], 1);
      chk("ovr_drain_b0", ev_btn[base+1], 0);
      chk("ovr_drain_code", ev_code[base+1], 1);
    end
    cyc_wait(20);

    // Reset in the middle of a long press
    base = ev_n;
    btn_status[0] = 1'b1;
    cyc_wait(15);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_btn", int'(evt_btn), 0);
    chk("mid_rst_code", int'(evt_code), 0);
    chk("mid_rst_ovr", int'(evt_overrun), 0);
    cyc_wait(3);
    reset_n = 1'b1;
    rr = cyc;
    cyc_wait(45);
    chk("rst_press_count", ev_n - base, 1);
    if (ev_n > base) begin
      chk("rst_press_btn", ev_btn[base], 0);
      chk("rst_press_code", ev_code[base], 2);
      chk("rst_press_lat", ev_cyc[base] - rr, 33);
    end
    btn_status = '0;
    cyc_wait(25);
    chk("rst_release_count", ev_n - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dio24_btn_events.md
DIO24_BTN_EVENTS -- requirements
Module: dio24_btn_events

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- NUM_BUTTONS, 2, number of debounced button inputs (>=1).
- TICK_BITS, 16, timebase prescaler width; one tick every 2^TICK_BITS clk cycles.
- CNT_BITS, 12, per-button tick counter width.
- LONG_TICKS, 1000, ticks held for long press (2..2^CNT_BITS-1).
- DBL_TICKS, 250, ticks released before a short press is final (2..2^CNT_BITS-1).
REQ-002 IDX_W SHALL be max(1, clog2(NUM_BUTTONS)).
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- btn_status  in  NUM_BUTTONS  debounced button levels, already synchronous to clk.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_btn  out  IDX_W  button index of event.
- evt_code  out  2  01 short, 10 long, 11 double.
- evt_overrun  out  1  sticky: event overwritten before delivery.
- ovr_clr  in  1  one-cycle clear of evt_overrun.

Function
REQ-004 A free-running TICK_BITS prescaler SHALL assert internal tick for one cycle when all ones.
REQ-005 Each button SHALL own an FSM {IDLE, PRESS, WAIT2, PRESS2, HOLD}, a CNT_BITS counter, a pending flag and a 2-bit pending code.
REQ-006 Counter SHALL clear on every state change and increment by 1 on each tick otherwise, saturating at all ones.
REQ-007 IDLE: btn high -> PRESS.
REQ-008 PRESS: tick with counter == LONG_TICKS-1 while btn high -> emit LONG, go HOLD; else btn low -> WAIT2; LONG wins if both hold in the same cycle.
REQ-009 WAIT2: btn high -> PRESS2; else tick with counter == DBL_TICKS-1 -> emit SHORT, go IDLE; press wins if both.
REQ-010 PRESS2: btn low -> emit DOUBLE, go IDLE; duration ignored, no LONG.
REQ-011 HOLD: btn low -> IDLE; no event.
REQ-012 Emitting SHALL set the button's pending flag and code at the same edge as the FSM transition.
REQ-013 Emitting while pending already set and not being loaded in that cycle SHALL overwrite the code and set evt_overrun.
REQ-014 Output register SHALL be loadable when evt_valid == 0 or (evt_valid & evt_ready); it loads the lowest-index pending button, clears that pending flag, sets evt_valid.
REQ-015 If a button is loaded and emits in the same cycle, the new event SHALL become pending without overrun.
REQ-016 With no pending button on a loadable cycle, evt_valid SHALL drop to 0 after a handshake.
REQ-017 evt_btn and evt_code SHALL remain stable while evt_valid & !evt_ready.
REQ-018 Minimum latency SHALL be one cycle: event emitted at edge E -> evt_valid high after edge E+1.
REQ-019 ovr_clr SHALL clear evt_overrun; a simultaneous set SHALL win.

Reset
REQ-020 reset_n low SHALL asynchronously force:
- FSMs to IDLE.
- Counters, prescaler and pending flags/codes to 0.
- evt_valid, evt_btn, evt_code and evt_overrun to 0.
REQ-021 Reset during a press SHALL discard it. After release of reset, a button still high SHALL enter PRESS as a new press.

Verification
REQ-022 The bench SHALL cover, with NUM_BUTTONS=2, TICK_BITS=2, LONG_TICKS=8, DBL_TICKS=4, evt_ready=1 unless stated:
- Short: btn0 high 10 cycles then low -> exactly one event {btn 0, code 01} 13..17 cycles after release; nothing else.
- Long: btn1 high 60 cycles -> one event {btn 1, code 10} 29..33 cycles after press, before release; none at release.
- Double: btn0 high 8, low 6, high 8, low -> one event {0, 11} one cycle after final release; no short.
- Arbitration: both buttons rise same cycle, held 40; evt_ready=0 until both pending -> {0,10} held stable, then {1,10} on the next cycle after the ready pulse; evt_valid low afterwards.
- Overrun: evt_ready=0, two short presses on btn0 with the output already occupied by btn1 -> evt_overrun=1, btn0 pending code 01; ovr_clr pulse -> 0.
- Reset: reset_n low 3 cycles mid long press of btn0 -> all outputs 0; no event for that press; the held button re-qualifies as a fresh press.
